// File: rtl/fmul_result_collector.sv
// fmul_result_collector
//   Collects results from the registered FP32 multiplier. Each accepted issue
//   is tracked through a LAT-deep valid/tag pipe. When the last stage is valid,
//   that cycle's multiplier outputs are packed into an IEEE word and written,
//   with the tag and flags, into a DEPTH-entry FIFO. A credit check guarantees
//   a FIFO slot for every operation in flight. Popped results accumulate
//   sticky IEEE exception flags.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   issue_valid/tag   operation launched into the multiplier this cycle
//   issue_ready       a FIFO slot is guaranteed for a new operation
//   Mz_in/Ez_in/Sz_in multiplier result fields, valid LAT cycles after issue
//   flags_in          {invalid, overflow, underflow, inexact, zero}
//   out_valid/ready   FIFO head handshake
//   out_data          {Sz, Ez, Mz} of the head entry
//   out_flags/out_tag flags and tag of the head entry
//   fflags            sticky {NV, OF, UF, NX}
//   fflags_clr        clears the sticky flags
//   count             FIFO occupancy
module fmul_result_collector #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_ready,
  input  logic [22:0]              Mz_in,
  input  logic [7:0]               Ez_in,
  input  logic                     Sz_in,
  input  logic [4:0]               flags_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [4:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [LAT-1:0]   pipe_v;
  logic [TAG_W-1:0] pipe_tag [LAT];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [31:0]      mem_data  [DEPTH];
  logic [4:0]       mem_flags [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];

  logic [31:0]      inflight;
  logic             accept;
  logic             push;
  logic             pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + 32'(pipe_v[i]);
    end
  end

  // Credits are taken from registered state only, so a pop frees its slot
  // for new issues one cycle later.
  assign issue_ready = (32'(count) + inflight) < DEPTH;
  assign accept      = issue_valid && issue_ready;

  // The credit check makes a full-FIFO push impossible; if it ever happens
  // the result is dropped rather than overwriting the head.
  assign push        = pipe_v[LAT-1] && (count != CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;

  // Memory is reset so the head outputs read as zero out of reset.
  assign out_data    = mem_data[rd_ptr];
  assign out_flags   = mem_flags[rd_ptr];
  assign out_tag     = mem_tag[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_tag[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_flags[i] <= '0;
        mem_tag[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      pipe_v[0]   <= accept;
      pipe_tag[0] <= issue_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      if (push) begin
        mem_data[wr_ptr]  <= {Sz_in, Ez_in, Mz_in};
        mem_flags[wr_ptr] <= flags_in;
        mem_tag[wr_ptr]   <= pipe_tag[LAT-1];
        wr_ptr            <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      count <= count + CW'(push) - CW'(pop);

      // Zero flag (bit 0) is never sticky; a popped result wins over a clear.
      fflags <= (fflags_clr ? 4'b0000 : fflags) |
                (pop ? mem_flags[rd_ptr][4:1] : 4'b0000);
    end
  end

endmodule
